// File: rtl/avgiq_accum_ctrl_if.sv
// avgiq_accum_ctrl_if: control word, sample stream and averaged result bundle for avgiq_accum_ctrl
interface avgiq_accum_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int AVG_LOG2_MAX = 10
) ();
  logic [31:0] ctrl_word;
  logic sync_in;
  logic valid_in;
  logic signed [DATA_W-1:0] i_in;
  logic signed [DATA_W-1:0] q_in;
  logic signed [DATA_W-1:0] avg_i;
  logic signed [DATA_W-1:0] avg_q;
  logic busy;
  logic done;
  logic [AVG_LOG2_MAX:0] frame_cnt;
  modport master (
    output ctrl_word, sync_in, valid_in, i_in, q_in,
    input avg_i, avg_q, busy, done, frame_cnt
  );
  modport slave (
    input ctrl_word, sync_in, valid_in, i_in, q_in,
    output avg_i, avg_q, busy, done, frame_cnt
  );
endinterface

// File: rtl/avgiq_accum_ctrl.sv
// avgiq_accum_ctrl: averages one channel's I/Q over 2^N frames; define AVGIQ_ROUND_EN for round-half-up
module avgiq_accum_ctrl #(
  parameter int DATA_W = 16,
  parameter int CH_W = 9,
  parameter int AVG_LOG2_MAX = 10
) (
  input logic user_clk,
  input logic user_rst,
  avgiq_accum_ctrl_if.slave bus
);
  localparam int ACC_W = DATA_W + AVG_LOG2_MAX;
  localparam int NW = $clog2(AVG_LOG2_MAX + 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT_SYNC = 2'd1, ACCUM = 2'd2, DONE = 2'd3;
  localparam logic [AVG_LOG2_MAX:0] CNT_ONE = 1;
  localparam logic [CH_W-1:0] CH_ONE = 1;
  logic [1:0] state;
  logic start_q, start_edge, hit, last;
  logic [CH_W-1:0] ch_cnt, ch_sel, idx;
  logic [NW-1:0] n_lat, n_req;
  logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
  logic [AVG_LOG2_MAX:0] cnt, cnt_nxt;
  logic signed [DATA_W-1:0] avg_i, avg_q;
  logic busy, done;
  logic unused_ctrl;
  assign unused_ctrl = ^{bus.ctrl_word[30:20], bus.ctrl_word[15:CH_W]};
  assign start_edge = bus.ctrl_word[31] & ~start_q;
  assign n_req = (32'(bus.ctrl_word[19:16]) > AVG_LOG2_MAX) ? NW'(AVG_LOG2_MAX) : NW'(bus.ctrl_word[19:16]);
  // a sync-tagged sample is channel 0 regardless of the running count
  assign idx = bus.sync_in ? '0 : ch_cnt;
  assign hit = bus.valid_in && idx == ch_sel && (state == ACCUM || (state == WAIT_SYNC && bus.sync_in));
  assign cnt_nxt = cnt + CNT_ONE;
  assign last = hit && cnt_nxt == (CNT_ONE << n_lat);
`ifdef AVGIQ_ROUND_EN
  assign sum_i = acc_i + ACC_W'((CNT_ONE << n_lat) >> 1);
  assign sum_q = acc_q + ACC_W'((CNT_ONE << n_lat) >> 1);
`else
  assign sum_i = acc_i;
  assign sum_q = acc_q;
`endif
  always_ff @(posedge user_clk) begin
    start_q <= bus.ctrl_word[31];
    if (user_rst) begin
      state <= IDLE;
      ch_cnt <= '0;
      ch_sel <= '0;
      n_lat <= '0;
      acc_i <= '0;
      acc_q <= '0;
      cnt <= '0;
      avg_i <= '0;
      avg_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      if (bus.valid_in) ch_cnt <= bus.sync_in ? CH_ONE : ch_cnt + CH_ONE;
      if (hit) begin
        acc_i <= acc_i + ACC_W'(bus.i_in);
        acc_q <= acc_q + ACC_W'(bus.q_in);
        cnt <= cnt_nxt;
      end
      case (state)
        IDLE: if (start_edge) begin
          state <= WAIT_SYNC;
          acc_i <= '0;
          acc_q <= '0;
          cnt <= '0;
          done <= 1'b0;
          busy <= 1'b1;
          ch_sel <= bus.ctrl_word[CH_W-1:0];
          n_lat <= n_req;
        end
        WAIT_SYNC, ACCUM: state <= last ? DONE : (bus.valid_in && bus.sync_in) ? ACCUM : state;
        default: begin
          avg_i <= DATA_W'(sum_i >>> n_lat);
          avg_q <= DATA_W'(sum_q >>> n_lat);
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
  assign bus.avg_i = avg_i;
  assign bus.avg_q = avg_q;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.frame_cnt = cnt;
endmodule

// File: tb/tb_avgiq_accum_ctrl.sv
// tb_avgiq_accum_ctrl: randomized and directed checks of avgiq_accum_ctrl against a transaction-level model
module tb_avgiq_accum_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  avgiq_accum_ctrl_if bus ();
  avgiq_accum_ctrl dut (.user_clk(clk), .user_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // reference state: capture progress kept as plain integers
  bit m_busy, m_done, m_prev, m_seen, m_fin;
  int m_idx, m_cnt, m_n, m_ch;
  longint m_si, m_sq;
  logic signed [15:0] m_ai = 0, m_aq = 0;

  function automatic int avg_of(longint s, int n);
    longint d = longint'(1) << n;
`ifdef AVGIQ_ROUND_EN
    s = s + d / 2;
`endif
    return int'(s >= 0 ? s / d : -((-s + d - 1) / d));
  endfunction

  task automatic model_step();
    bit edge_s;
    int this_ch;
    if (rst) begin
      m_busy = 0; m_done = 0; m_fin = 0; m_cnt = 0; m_idx = 0;
      m_ai = 0; m_aq = 0; m_prev = bus.ctrl_word[31];
      return;
    end
    edge_s = bus.ctrl_word[31] && !m_prev;
    m_prev = bus.ctrl_word[31];
    this_ch = bus.sync_in ? 0 : m_idx;
    if (bus.valid_in) m_idx = bus.sync_in ? 1 : (m_idx + 1) % 512;
    if (m_fin) begin
      m_fin = 0; m_busy = 0; m_done = 1;
      m_ai = 16'(avg_of(m_si, m_n));
      m_aq = 16'(avg_of(m_sq, m_n));
    end else if (!m_busy) begin
      if (edge_s) begin
        m_busy = 1; m_done = 0; m_cnt = 0; m_si = 0; m_sq = 0; m_seen = 0;
        m_ch = int'(bus.ctrl_word[8:0]);
        m_n = (bus.ctrl_word[19:16] > 10) ? 10 : int'(bus.ctrl_word[19:16]);
      end
    end else if (bus.valid_in && (m_seen || bus.sync_in)) begin
      m_seen = 1;
      if (this_ch == m_ch) begin
        m_si += longint'(bus.i_in);
        m_sq += longint'(bus.q_in);
        m_cnt++;
        if (m_cnt == (1 << m_n)) m_fin = 1;
      end
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    tests++;
    if (bus.busy !== m_busy || bus.done !== m_done || bus.avg_i !== m_ai || bus.avg_q !== m_aq || bus.frame_cnt !== 11'(m_cnt)) begin
      fails++;
      $display("FAIL cycle_check t=%0t busy=%b/%b done=%b/%b avg_i=%0d/%0d avg_q=%0d/%0d frame_cnt=%0d/%0d (got/want)",
               $time, bus.busy, m_busy, bus.done, m_done, bus.avg_i, m_ai, bus.avg_q, m_aq, bus.frame_cnt, m_cnt);
    end
  end

  task automatic check(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic drive(bit s, bit v, int i, int q);
    bus.sync_in = s; bus.valid_in = v; bus.i_in = 16'(i); bus.q_in = 16'(q);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0);
  endtask

  task automatic start_cmd(int ch, int n);
    bus.ctrl_word = 32'h0;
    idle(1);
    bus.ctrl_word = 32'h8000_0000 | (32'(n) << 16) | 32'(ch);
    idle(1);
  endtask

  task automatic send_frame(int len, int ch, int vi, int vq, bit gaps);
    for (int k = 0; k < len; k++) begin
      if (gaps && $urandom_range(3) == 0) drive(bit'($urandom_range(1)), 0, int'($urandom), int'($urandom));
      drive(k == 0, 1, k == ch ? vi : int'($signed(16'($urandom))), k == ch ? vq : int'($signed(16'($urandom))));
    end
  endtask

  initial begin
    int bi[4] = '{100, 101, 102, 103};
    int bq[4] = '{-4, -4, -4, -8};
    int ri[4] = '{1, 0, 0, 0};
    int ch, n, f;
    bus.ctrl_word = 32'h8000_0000;
    bus.sync_in = 0; bus.valid_in = 0; bus.i_in = 0; bus.q_in = 0;
    idle(3);
    chk_en = 1;
    rst = 0;
    idle(5);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_avg_i", int'(bus.avg_i), 0);
    check("reset_avg_q", int'(bus.avg_q), 0);

    start_cmd(5, 2);
    repeat (3) drive(0, 1, 55, 55);
    for (int k = 0; k < 4; k++) send_frame(6, 5, bi[k], bq[k], 0);
    check("basic_done_plus1", int'(bus.done), 0);
    idle(1);
    check("basic_done_plus2", int'(bus.done), 1);
`ifdef AVGIQ_ROUND_EN
    check("basic_avg_i", int'(bus.avg_i), 102);
    check("model_avg_i", int'(m_ai), 102);
`else
    check("basic_avg_i", int'(bus.avg_i), 101);
    check("model_avg_i", int'(m_ai), 101);
`endif
    check("basic_avg_q", int'(bus.avg_q), -5);
    check("model_avg_q", int'(m_aq), -5);
    check("basic_frame_cnt", int'(bus.frame_cnt), 4);

    start_cmd(5, 2);
    for (int k = 0; k < 4; k++) send_frame(6, 5, ri[k], 0, 0);
    idle(2);
    check("round_small_avg_i", int'(bus.avg_i), 0);

    for (int r = 0; r < 8; r++) begin
      ch = $urandom_range(0, 12);
      n = $urandom_range(0, 3);
      f = 0;
      start_cmd(ch, n);
      while (m_busy && f < 200) begin
        send_frame($urandom_range(1, ch + 4), ch, int'($signed(16'($urandom))), int'($signed(16'($urandom))), 1);
        if ($urandom_range(3) == 0 && m_cnt < (1 << n) - 1) bus.ctrl_word[31] = ~bus.ctrl_word[31];
        f++;
      end
      idle(2);
      check("rand_done", int'(bus.done), 1);
      check("rand_frame_cnt", int'(bus.frame_cnt), 1 << n);
    end

    start_cmd(2, 1);
    send_frame(4, 2, 10, 20, 0);
    bus.ctrl_word[31] = 0;
    idle(1);
    bus.ctrl_word[31] = 1;
    idle(1);
    check("restart_ignored_busy", int'(bus.busy), 1);
    check("restart_ignored_cnt", int'(bus.frame_cnt), 1);
    send_frame(4, 2, 30, 40, 0);
    idle(2);
    check("restart_done", int'(bus.done), 1);
    check("restart_frame_cnt", int'(bus.frame_cnt), 2);
    check("restart_avg_i", int'(bus.avg_i), 20);
    check("restart_avg_q", int'(bus.avg_q), 30);

    start_cmd(0, 15);
    repeat (1024) drive(1, 1, -32768, 32767);
    idle(2);
    check("full_avg_i", int'(bus.avg_i), -32768);
    check("full_avg_q", int'(bus.avg_q), 32767);
    check("full_clamp_cnt", int'(bus.frame_cnt), 1024);

    start_cmd(511, 1);
    repeat (2) send_frame(512, 511, -32768, 100, 0);
    idle(2);
    check("ch511_avg_i", int'(bus.avg_i), -32768);
    check("ch511_avg_q", int'(bus.avg_q), 100);

    start_cmd(3, 2);
    repeat (2) send_frame(4, 3, 9, 9, 0);
    rst = 1;
    idle(1);
    check("rst_mid_busy", int'(bus.busy), 0);
    check("rst_mid_cnt", int'(bus.frame_cnt), 0);
    bus.ctrl_word = 32'h0;
    idle(1);
    bus.ctrl_word = 32'h8000_0000;
    idle(1);
    rst = 0;
    idle(3);
    check("start_in_rst_busy", int'(bus.busy), 0);
    start_cmd(0, 0);
    drive(1, 1, 7, -3);
    idle(2);
    check("n0_done", int'(bus.done), 1);
    check("n0_avg_i", int'(bus.avg_i), 7);
    check("n0_avg_q", int'(bus.avg_q), -3);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
